// File: rtl/mem_stage_pkg.sv
// ============================================================================
// Module : mem_stage_pkg
// Brief  : Shared constants for the MEM stage: rf bundle width, load-op one-hot.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_stage_pkg;

  localparam int RZ      = 38;
  localparam int LD_OP_W = 5;

  // One-hot bit positions inside es_ld_op, same order EX uses to build it
  localparam int LD_B  = 0;
  localparam int LD_BU = 1;
  localparam int LD_H  = 2;
  localparam int LD_HU = 3;
  localparam int LD_W  = 4;

endpackage

`default_nettype wire

// File: rtl/load_extend.sv
// ============================================================================
// Module : load_extend
// Brief  : Selects byte/half/word from a read word and sign/zero-extends it.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module load_extend
  import mem_stage_pkg::*;
(
  input  logic [31:0]         rdata,
  input  logic [1:0]          offset,
  input  logic [LD_OP_W-1:0]  ld_op,
  output logic [31:0]         ld_result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte    = rdata[{offset, 3'b000} +: 8];
    // Halfword misalignment is not trapped here; offset[0] is simply ignored
    w_half    = offset[1] ? rdata[31:16] : rdata[15:0];
    ld_result = '0;
    if (ld_op[LD_B])       ld_result = {{24{w_byte[7]}}, w_byte};
    else if (ld_op[LD_BU]) ld_result = {24'd0, w_byte};
    else if (ld_op[LD_H])  ld_result = {{16{w_half[15]}}, w_half};
    else if (ld_op[LD_HU]) ld_result = {16'd0, w_half};
    else if (ld_op[LD_W])  ld_result = rdata;
  end

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// ============================================================================
// Module : mem_stage
// Brief  : CPU MEM stage: captures SRAM load data, forms the write-back bundle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DW = 32,
  parameter int RZ = 38
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                es2ms_valid,
  output logic                ms_allowin,
  input  logic [DW-1:0]       es_pc,
  input  logic [RZ-1:0]       es_rf_zip,
  input  logic [LD_OP_W-1:0]  es_ld_op,
  input  logic [31:0]         data_sram_rdata,
  input  logic                ws_allowin,
  output logic                ms2ws_valid,
  output logic [DW-1:0]       ms_pc,
  output logic [RZ-1:0]       ms_rf_zip,
  output logic                ms_ld_busy
);

  logic               r_ms_valid;
  logic [DW-1:0]      r_pc;
  logic               r_rf_we;
  logic [4:0]         r_waddr;
  logic [DW-1:0]      r_alu_result;
  logic [LD_OP_W-1:0] r_ld_op;
  logic [31:0]        r_rdata_buf;
  logic               r_buf_valid;
  logic               r_first_cyc;

  logic               w_ms_ready_go;
  logic               w_ms_allowin;
  logic               w_accept;
  logic               w_leave;
  logic [31:0]        w_sel_rdata;
  logic [31:0]        w_ld_result;
  logic [DW-1:0]      w_wdata;

  assign w_ms_ready_go = 1'b1;
  assign w_ms_allowin  = ~r_ms_valid | (w_ms_ready_go & ws_allowin);
  assign w_accept      = es2ms_valid & w_ms_allowin;
  assign w_leave       = r_ms_valid & w_ms_ready_go & ws_allowin;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ms_valid   <= 1'b0;
      r_pc         <= '0;
      r_rf_we      <= 1'b0;
      r_waddr      <= '0;
      r_alu_result <= '0;
      r_ld_op      <= '0;
      r_first_cyc  <= 1'b0;
    end else begin
      if (w_ms_allowin) r_ms_valid <= es2ms_valid;
      if (w_accept) begin
        r_pc         <= es_pc;
        r_rf_we      <= es_rf_zip[DW+5];
        r_waddr      <= es_rf_zip[DW+4:DW];
        r_alu_result <= es_rf_zip[DW-1:0];
        r_ld_op      <= es_ld_op;
      end
      r_first_cyc <= w_accept;
    end
  end

  // The SRAM response is only present in the first MEM cycle; hold it across a stall
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rdata_buf <= '0;
      r_buf_valid <= 1'b0;
    end else if (w_leave) begin
      r_buf_valid <= 1'b0;
    end else if (r_first_cyc && !ws_allowin) begin
      r_rdata_buf <= data_sram_rdata;
      r_buf_valid <= 1'b1;
    end
  end

  assign w_sel_rdata = r_buf_valid ? r_rdata_buf : data_sram_rdata;

  load_extend u_load_extend (
    .rdata     (w_sel_rdata),
    .offset    (r_alu_result[1:0]),
    .ld_op     (r_ld_op),
    .ld_result (w_ld_result)
  );

  assign w_wdata     = (|r_ld_op) ? w_ld_result : r_alu_result;
  assign ms_allowin  = w_ms_allowin;
  assign ms2ws_valid = r_ms_valid & w_ms_ready_go;
  assign ms_pc       = r_pc;
  assign ms_rf_zip   = {r_rf_we & r_ms_valid, r_waddr, w_wdata};
  assign ms_ld_busy  = r_ms_valid & (|r_ld_op);

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
// Module : tb_mem_stage
// Brief  : Self-checking bench for mem_stage with a behavioural stage model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_stage;

  logic        clk;
  logic        resetn;
  logic        es2ms_valid;
  logic        ms_allowin;
  logic [31:0] es_pc;
  logic [37:0] es_rf_zip;
  logic [4:0]  es_ld_op;
  logic [31:0] data_sram_rdata;
  logic        ws_allowin;
  logic        ms2ws_valid;
  logic [31:0] ms_pc;
  logic [37:0] ms_rf_zip;
  logic        ms_ld_busy;

  int tests;
  int failed;

  // Model of the single instruction held in MEM
  logic        m_valid, m_first, m_we;
  logic [31:0] m_pc, m_alu, m_word;
  logic [4:0]  m_waddr, m_op;

  logic [37:0] obs_zip;
  logic        obs_busy, obs_allow, obs_ms2ws;

  mem_stage #(.DW(32), .RZ(38)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .es2ms_valid     (es2ms_valid),
    .ms_allowin      (ms_allowin),
    .es_pc           (es_pc),
    .es_rf_zip       (es_rf_zip),
    .es_ld_op        (es_ld_op),
    .data_sram_rdata (data_sram_rdata),
    .ws_allowin      (ws_allowin),
    .ms2ws_valid     (ms2ws_valid),
    .ms_pc           (ms_pc),
    .ms_rf_zip       (ms_rf_zip),
    .ms_ld_busy      (ms_ld_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_wdata(input logic [4:0] op, input logic [31:0] alu,
                                              input logic [31:0] word);
    int unsigned off;
    logic [31:0] b, h;
    off = alu[1:0];
    b = (word >> (off * 8)) & 32'hFF;
    h = (word >> ((off / 2) * 16)) & 32'hFFFF;
    case (op)
      5'b00001: return (b >= 32'h80)   ? b - 32'h100   : b;
      5'b00010: return b;
      5'b00100: return (h >= 32'h8000) ? h - 32'h10000 : h;
      5'b01000: return h;
      5'b10000: return word;
      default:  return alu;
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 0; m_first = 0; m_we = 0;
    m_pc = 0; m_alu = 0; m_word = 0; m_waddr = 0; m_op = 0;
  endtask

  // One cycle: drive at negedge, check mid-cycle, advance model at posedge
  task automatic step(input logic v, input logic [31:0] pc, input logic [37:0] zip,
                      input logic [4:0] op, input logic [31:0] rd, input logic ws);
    logic exp_allow;
    es2ms_valid = v; es_pc = pc; es_rf_zip = zip; es_ld_op = op;
    data_sram_rdata = rd; ws_allowin = ws;
    #1;
    if (m_first) m_word = rd;
    exp_allow = !m_valid || ws;
    obs_zip = ms_rf_zip; obs_busy = ms_ld_busy; obs_allow = ms_allowin; obs_ms2ws = ms2ws_valid;
    chk("allowin", 64'(ms_allowin), 64'(exp_allow));
    chk("ms2ws_valid", 64'(ms2ws_valid), 64'(m_valid));
    chk("ld_busy", 64'(ms_ld_busy), 64'(m_valid && m_op != 0));
    if (m_valid) begin
      chk("pc", 64'(ms_pc), 64'(m_pc));
      chk("rf_zip", 64'(ms_rf_zip), 64'({m_we, m_waddr, model_wdata(m_op, m_alu, m_word)}));
    end else begin
      chk("bubble_we", 64'(ms_rf_zip[37]), 64'(0));
    end
    @(posedge clk);
    m_first = 0;
    if (exp_allow) begin
      m_valid = v;
      if (v) begin
        m_pc = pc; m_we = zip[37]; m_waddr = zip[36:32]; m_alu = zip[31:0]; m_op = op;
        m_first = 1;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    logic [4:0] rop;
    tests = 0; failed = 0;
    resetn = 1; es2ms_valid = 0; es_pc = 0; es_rf_zip = 0; es_ld_op = 0;
    data_sram_rdata = 0; ws_allowin = 1;
    model_reset();

    // Asynchronous reset mid-cycle
    #3 resetn = 0;
    #1;
    chk("rst_ms2ws", 64'(ms2ws_valid), 64'(0));
    chk("rst_allowin", 64'(ms_allowin), 64'(1));
    chk("rst_zip", 64'(ms_rf_zip), 64'(0));
    chk("rst_pc", 64'(ms_pc), 64'(0));
    chk("rst_busy", 64'(ms_ld_busy), 64'(0));
    @(negedge clk); @(negedge clk);
    resetn = 1;
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);

    // ld_b / ld_bu at offset 3
    step(1, 32'h100, {1'b1, 5'd5, 32'h2003}, 5'b00001, 32'h0, 1);
    step(0, 0, 0, 0, 32'h80AA_5511, 1);
    chk("ld_b_zip", 64'(obs_zip), 64'({1'b1, 5'd5, 32'hFFFF_FF80}));
    step(1, 32'h104, {1'b1, 5'd5, 32'h2003}, 5'b00010, 32'h0, 1);
    step(0, 0, 0, 0, 32'h80AA_5511, 1);
    chk("ld_bu_zip", 64'(obs_zip), 64'({1'b1, 5'd5, 32'h0000_0080}));

    // ld_h at offset 2, ld_hu at offset 0
    step(1, 32'h108, {1'b1, 5'd6, 32'h3002}, 5'b00100, 32'h0, 1);
    step(1, 32'h10C, {1'b1, 5'd6, 32'h3000}, 5'b01000, 32'h8001_7FFF, 1);
    chk("ld_h_zip", 64'(obs_zip), 64'({1'b1, 5'd6, 32'hFFFF_8001}));
    step(0, 0, 0, 0, 32'h8001_7FFF, 1);
    chk("ld_hu_zip", 64'(obs_zip), 64'({1'b1, 5'd6, 32'h0000_7FFF}));

    // Backpressure on ld_w with changing SRAM data; an add waits in EX
    step(1, 32'h200, {1'b1, 5'd9, 32'h4000}, 5'b10000, 32'h0, 1);
    step(1, 32'h204, {1'b1, 5'd10, 32'h33}, 5'b00000, 32'h1234_5678, 0);
    chk("stall_allowin", 64'(obs_allow), 64'(0));
    step(1, 32'h204, {1'b1, 5'd10, 32'h33}, 5'b00000, 32'hDEAD_BEEF, 0);
    step(1, 32'h204, {1'b1, 5'd10, 32'h33}, 5'b00000, 32'hDEAD_BEEF, 0);
    chk("stall_wdata", 64'(obs_zip[31:0]), 64'(32'h1234_5678));
    step(1, 32'h204, {1'b1, 5'd10, 32'h33}, 5'b00000, 32'hDEAD_BEEF, 1);
    chk("stall_release", 64'(obs_ms2ws), 64'(1));
    step(0, 0, 0, 0, 32'hDEAD_BEEF, 1);
    chk("add_after_stall", 64'(obs_zip), 64'({1'b1, 5'd10, 32'h33}));

    // add, bubble, ld_w
    step(1, 32'h300, {1'b1, 5'd3, 32'h11}, 5'b00000, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("add_wdata", 64'(obs_zip), 64'({1'b1, 5'd3, 32'h11}));
    chk("add_busy", 64'(obs_busy), 64'(0));
    step(1, 32'h308, {1'b1, 5'd4, 32'h5000}, 5'b10000, 0, 1);
    chk("bubble_we0", 64'(obs_zip[37]), 64'(0));
    step(0, 0, 0, 0, 32'hCAFE_F00D, 1);
    chk("ld_busy1", 64'(obs_busy), 64'(1));
    step(0, 0, 0, 0, 0, 1);
    chk("ld_busy0", 64'(obs_busy), 64'(0));

    // Reset during a stalled load
    step(1, 32'h400, {1'b1, 5'd7, 32'h6000}, 5'b10000, 0, 1);
    step(0, 0, 0, 0, 32'hAAAA_5555, 0);
    step(0, 0, 0, 0, 32'h0, 0);
    #2 resetn = 0;
    #1;
    chk("rst_stall_buf", 64'(dut.r_buf_valid), 64'(0));
    chk("rst_stall_valid", 64'(ms2ws_valid), 64'(0));
    chk("rst_stall_allow", 64'(ms_allowin), 64'(1));
    model_reset();
    @(negedge clk);
    resetn = 1;
    step(0, 0, 0, 0, 0, 1);
    chk("rst_no_xfer", 64'(obs_ms2ws), 64'(0));

    // Randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      int r;
      r = $urandom_range(0, 5);
      rop = (r == 0) ? 5'b0 : 5'(1 << (r - 1));
      step(1'($urandom_range(0, 3) != 0), $urandom,
           {1'($urandom), 5'($urandom), 32'($urandom)}, rop, $urandom,
           1'($urandom_range(0, 9) < 7));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Memory-access pipeline stage of the 5-stage CPU. It sits between the EX stage and the WB stage and drives the producer side of the MEM→WB valid/allowin handshake. It captures the data SRAM read response, extracts and extends load data, and forms the {we, waddr, wdata} write-back bundle. The same bundle is exposed to ID for forwarding.

Parameters:
- DW, 32, data/PC width.
- RZ, 38, width of the rf bundle {we[1], waddr[5], wdata[32]}.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- es2ms_valid  in  1  EX holds a valid instruction for MEM.
- ms_allowin  out  1  MEM can accept from EX this cycle.
- es_pc  in  32  PC of the EX instruction.
- es_rf_zip  in  38  {we, waddr, alu_result}; alu_result is the load address for loads.
- es_ld_op  in  5  one-hot {ld_w, ld_hu, ld_h, ld_bu, ld_b}; all zero means not a load.
- data_sram_rdata  in  32  SRAM read data, valid exactly one cycle after the EX-stage request.
- ws_allowin  in  1  WB can accept.
- ms2ws_valid  out  1  MEM hands a valid instruction to WB.
- ms_pc  out  32  PC to WB.
- ms_rf_zip  out  38  {we & ms_valid, waddr, final wdata} to WB and to ID bypass.
- ms_ld_busy  out  1  ms_valid & current op is a load (ID load-use hint).

Behaviour:
- Reset (asynchronous, resetn=0) clears ms_valid, ms_pc, all bundle and ld_op registers, rdata_buf, buf_valid and first_cyc to 0. All outputs therefore read 0 and ms_allowin=1.
- ms_ready_go = 1.
- ms_allowin = ~ms_valid | (ms_ready_go & ws_allowin).
- ms2ws_valid = ms_valid & ms_ready_go.
- If ms_allowin, ms_valid <= es2ms_valid.
- On es2ms_valid & ms_allowin, latch es_pc, es_rf_zip, es_ld_op and alu_result[1:0] (offset), and set first_cyc=1. Otherwise first_cyc <= 0.
- A load that is accepted and not stalled reaches WB one cycle later.
- Response capture: data_sram_rdata is valid only when first_cyc=1.
  - If first_cyc & ~ws_allowin: rdata_buf <= data_sram_rdata and buf_valid <= 1.
  - buf_valid clears when ms2ws_valid & ws_allowin.
  - Selected read data: buf_valid ? rdata_buf : data_sram_rdata.
- Load extraction from the selected word:
  - ld_b / ld_bu: byte at offset*8, sign- or zero-extended to 32 bits.
  - ld_h / ld_hu: half at offset[1]*16 (offset[0] ignored; misalignment is not trapped in this block), sign- or zero-extended.
  - ld_w: whole word; offset ignored.
  - Non-load: wdata = latched alu_result.
- ms_rf_zip[37] = ms_rf_we & ms_valid. A bubble never asserts we.
- Simultaneous accept and leave: when ws_allowin=1 and ms_valid, a new instruction is latched in the same edge the old one leaves. No bubble is inserted.
- Reset mid-load: the stage is cleared immediately and the pending SRAM response is discarded.
- buf_valid never stays set while ms_valid=0.

Decomposition:
- Shared package: constants RZ=38, LD_OP_W=5, and the one-hot bit indices LD_B=0, LD_BU=1, LD_H=2, LD_HU=3, LD_W=4. Use the same bit order EX uses when it builds es_ld_op.
- One combinational sub-module, load_extend (inputs rdata[31:0], offset[1:0], ld_op[4:0]; output ld_result[31:0]). It is reused later for store/exception stages.

Test Plan:
- Reset: resetn=0 asynchronously mid-cycle → all outputs 0, ms_allowin=1. Release with es2ms_valid=0 → ms2ws_valid stays 0.
- ld_b with offset=3, rdata=0x80AA_5511, waddr=5, ws_allowin=1 → next cycle ms2ws_valid=1, ms_rf_zip={1,5,0xFFFF_FF80}. Same case with ld_bu → wdata 0x0000_0080.
- ld_h with offset=2, rdata=0x8001_7FFF → wdata 0xFFFF_8001. ld_hu with offset=0 on the same word → wdata 0x0000_7FFF.
- Backpressure: ld_w, rdata=0x1234_5678 in first_cyc, ws_allowin=0 for 3 cycles while SRAM input changes to 0xDEAD_BEEF. Then → ms_allowin=0 during the stall, wdata stays 0x1234_5678, and the instruction transfers once on ws_allowin=1.
- Back-to-back: add (wdata 0x11, we=1) followed by a bubble then ld_w. Check the bubble has ms_rf_zip[37]=0, and ms_ld_busy=1 only in the load's cycle.
- Reset asserted during the stall above → buf_valid=0, ms_valid=0, no WB transfer after release.
